// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB sequencing,
// IR decode into datapath selects, and a retired-instruction counter.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             im_req,
    output logic             dm_req,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       NPCOp,
    output logic             RegWr,
    output logic [1:0]       RegDst,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       EOp,
    output logic [1:0]       MemtoReg,
    output logic             MemWr,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0] op, funct;
    logic is_r, is_addu, is_subu, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;
    logic [1:0] eop_dec;
    logic [2:0] aluop_dec;
    logic       alusrc_dec;
    logic       unused_instr;

    assign op      = instr[31:26];
    assign funct   = instr[5:0];
    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_legal = is_addu | is_subu | is_ori | is_lui | is_lw |
                      is_sw | is_beq | is_j | is_jal;
    assign unused_instr = ^instr[25:6];

    assign eop_dec = is_ori ? 2'b01 :
                     is_lui ? 2'b10 :
                     is_beq ? 2'b11 : 2'b00;
    assign alusrc_dec = is_ori | is_lui | is_lw | is_sw;
    assign aluop_dec  = (is_subu | is_beq) ? 3'b001 :
                        is_ori             ? 3'b010 :
                        is_lui             ? 3'b011 : 3'b000;

    always_comb begin
        state_d  = state_q;
        im_req   = 1'b0;
        dm_req   = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        NPCOp    = 2'b00;
        RegWr    = 1'b0;
        RegDst   = 2'b00;
        ALUSrc   = 1'b0;
        ALUOp    = 3'b000;
        EOp      = 2'b00;
        MemtoReg = 2'b00;
        MemWr    = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                EOp = eop_dec;
                // Illegal ops retire as a nop; the PC already moved in FETCH.
                if (!is_legal) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                EOp    = eop_dec;
                ALUSrc = alusrc_dec;
                ALUOp  = aluop_dec;
                if (is_beq) begin
                    NPCOp   = 2'b01;
                    PCWr    = zero;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    NPCOp   = 2'b10;
                    PCWr    = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    NPCOp   = is_jal ? 2'b10 : 2'b00;
                    PCWr    = is_jal;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dm_req = 1'b1;
                MemWr  = is_sw;
                if (dm_ready) begin
                    retire  = is_sw;
                    state_d = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                RegWr    = 1'b1;
                retire   = 1'b1;
                RegDst   = is_jal ? 2'b10 : (is_addu | is_subu) ? 2'b01 : 2'b00;
                MemtoReg = is_jal ? 2'b10 : is_lw ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Nothing may commit while reset is held, even in FETCH.
        if (reset) begin
            IRWr   = 1'b0;
            PCWr   = 1'b0;
            RegWr  = 1'b0;
            MemWr  = 1'b0;
            retire = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expected cycle traces from
// the ISA timing rules, compared each cycle by an independent monitor.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] instr = '0;
    logic zero = 0, im_ready = 1, dm_ready = 0;
    logic im_req, dm_req, IRWr, PCWr, RegWr, ALUSrc, MemWr, retire;
    logic [1:0] NPCOp, RegDst, EOp, MemtoReg;
    logic [2:0] ALUOp, state;
    logic [CW-1:0] retired_cnt;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .im_req(im_req), .dm_req(dm_req), .IRWr(IRWr), .PCWr(PCWr),
        .NPCOp(NPCOp), .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .EOp(EOp), .MemtoReg(MemtoReg), .MemWr(MemWr),
        .retire(retire), .retired_cnt(retired_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic im_req, dm_req, irwr, pcwr;
        logic [1:0] npc;
        logic regwr;
        logic [1:0] regdst;
        logic alusrc;
        logic [2:0] aluop;
        logic [1:0] eop, m2r;
        logic memwr, retire;
        logic [CW-1:0] cnt;
    } exp_t;

    localparam int ADDU = 0, SUBU = 1, ORI = 2, LUI = 3, LW = 4;
    localparam int SW = 5, BEQ = 6, J = 7, JAL = 8, ILL = 9;

    exp_t act;
    assign act = '{state, im_req, dm_req, IRWr, PCWr, NPCOp, RegWr, RegDst,
                   ALUSrc, ALUOp, EOp, MemtoReg, MemWr, retire, retired_cnt};

    exp_t sbq[$];
    int n_cmp = 0, n_bad = 0, mcnt = 0;

    task automatic check(input string nm, input logic [31:0] got, want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL cycle st=%0d: got %h want %h (t=%0t)",
                         e.st, act, e, $time);
            end
        end
    end

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic [31:0] enc(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            ADDU: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            SUBU: begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            ORI:  r[31:26] = 6'h0D;
            LUI:  r[31:26] = 6'h0F;
            LW:   r[31:26] = 6'h23;
            SW:   r[31:26] = 6'h2B;
            BEQ:  r[31:26] = 6'h04;
            J:    r[31:26] = 6'h02;
            JAL:  r[31:26] = 6'h03;
            default: begin
                case ($urandom_range(2))
                    0: r[31:26] = 6'h3F;
                    1: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
                    default: r[31:26] = 6'h08;
                endcase
            end
        endcase
        return r;
    endfunction

    // One controller cycle: drive inputs, queue the expected outputs.
    task automatic cyc(input exp_t e, input logic imr, dmr, z);
        im_ready = imr;
        dm_ready = dmr;
        zero = z;
        e.cnt = CW'(mcnt);
        sbq.push_back(e);
        if (e.retire) mcnt = (mcnt + 1) % (1 << CW);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic run_instr(input int k, input int f, m,
                             input logic z, input bit rst_in_mem);
        exp_t e;
        instr = enc(k);
        if (k == ORI) instr[15:0] = 16'hFFFF;
        repeat (f) begin
            e = base(0); e.im_req = 1;
            cyc(e, 0, rb(), rb());
        end
        e = base(0); e.im_req = 1; e.irwr = 1; e.pcwr = 1;
        cyc(e, 1, rb(), rb());
        e = base(1);
        e.eop = (k == ORI) ? 2'b01 : (k == LUI) ? 2'b10 :
                (k == BEQ) ? 2'b11 : 2'b00;
        e.retire = (k == ILL);
        cyc(e, rb(), rb(), rb());
        if (k == ILL) return;
        e.st = 2; e.retire = 0;
        e.alusrc = (k == ORI || k == LUI || k == LW || k == SW);
        e.aluop = (k == SUBU || k == BEQ) ? 3'd1 : (k == ORI) ? 3'd2 :
                  (k == LUI) ? 3'd3 : 3'd0;
        if (k == BEQ) begin e.npc = 2'b01; e.pcwr = z; e.retire = 1; end
        if (k == J || k == JAL) begin e.npc = 2'b10; e.pcwr = 1; end
        if (k == J) e.retire = 1;
        cyc(e, rb(), rb(), z);
        if (k == BEQ || k == J) return;
        if (k == LW || k == SW) begin
            if (rst_in_mem) begin
                dm_ready = 0;
                im_ready = 1;
                #2 reset = 1;
                #1;
                check("rst_state", 32'(state), 0);
                check("rst_memwr", 32'(MemWr), 0);
                check("rst_cnt", 32'(retired_cnt), 0);
                check("rst_irwr", 32'(IRWr), 0);
                check("rst_retire", 32'(retire), 0);
                @(posedge clk);
                #1 reset = 0;
                mcnt = 0;
                return;
            end
            e = base(3); e.dm_req = 1; e.memwr = (k == SW);
            repeat (m) cyc(e, rb(), 0, rb());
            e.retire = (k == SW);
            cyc(e, rb(), 1, rb());
            if (k == SW) return;
        end
        e = base(4); e.regwr = 1; e.retire = 1;
        e.regdst = (k == JAL) ? 2'b10 : (k == ADDU || k == SUBU) ? 2'b01 : 2'b00;
        e.m2r = (k == JAL) ? 2'b10 : (k == LW) ? 2'b01 : 2'b00;
        cyc(e, rb(), rb(), rb());
    endtask

    initial begin
        #3;
        check("reset_state", 32'(state), 0);
        check("reset_cnt", 32'(retired_cnt), 0);
        check("reset_imreq", 32'(im_req), 1);
        check("reset_irwr_gated", 32'(IRWr), 0);
        check("reset_retire", 32'(retire), 0);
        @(posedge clk);
        #1 reset = 0;
        run_instr(ORI, 0, 0, 0, 0);
        check("ori_cnt", 32'(retired_cnt), 1);
        run_instr(LW, 0, 3, 0, 0);
        run_instr(BEQ, 0, 0, 1, 0);
        run_instr(BEQ, 0, 0, 0, 0);
        run_instr(JAL, 1, 0, 0, 0);
        run_instr(ILL, 0, 0, 0, 0);
        run_instr(ADDU, 5, 0, 0, 0);
        run_instr(SW, 0, 2, 0, 1);
        run_instr(SUBU, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++)
            run_instr($urandom_range(9), $urandom_range(2),
                      $urandom_range(3), rb(), ($urandom_range(15) == 0));
        @(negedge clk);
        #1;
        check("queue_drained", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the single-issue MIPS datapath. It sequences FETCH/DECODE/EXE/MEM/WB and decodes the instruction register. It drives every datapath select, including the immediate extender's EOp, the write enables, and the instruction/data memory request handshakes. It also keeps a retired-instruction counter for the bench.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  32  current IR contents (op=instr[31:26], funct=instr[5:0])
zero  input  1  ALU equal flag, valid in EXE
im_ready  input  1  instruction memory has data this cycle
dm_ready  input  1  data memory completes access this cycle
im_req  output  1  instruction fetch request
dm_req  output  1  data memory request
IRWr  output  1  IR load enable
PCWr  output  1  PC load enable
NPCOp  output  2  00 PC+4, 01 branch (PC+4+ext), 10 jump {PC[31:28],idx,00}
RegWr  output  1  GRF write enable
RegDst  output  2  00 rt, 01 rd, 10 $31
ALUSrc  output  1  0 rt data, 1 ext output
ALUOp  output  3  000 add, 001 sub, 010 or, 011 pass B
EOp  output  2  00 sign, 01 zero, 10 lui (imm<<16), 11 sign<<2
MemtoReg  output  2  00 ALU, 01 mem, 10 PC
MemWr  output  1  DM write enable
retire  output  1  one-cycle pulse when an instruction completes
retired_cnt  output  CNT_W  count of retired instructions
state  output  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4

Behaviour:
- Supported instructions: addu(0/100001), subu(0/100011), ori(001101), lui(001111), lw(100011), sw(101011), beq(000100), j(000010), jal(000011). Anything else is illegal.
- Reset (async, immediate): state=FETCH, retired_cnt=0, retire=0.
- All other outputs are combinational Moore/IR decode, so after reset they take their FETCH values: im_req=1; IRWr and PCWr follow im_ready; the rest are 0.
- Reset asserted mid-instruction abandons it. No write enable may be high while reset=1.
- FETCH:
  - im_req=1, NPCOp=00.
  - If im_ready: IRWr=1, PCWr=1, next DECODE. Otherwise hold with IRWr=PCWr=0, for any number of cycles.
- DECODE:
  - Drive EOp for the instruction: ori 01, lui 10, lw/sw 00, beq 11, else 00.
  - Illegal op: retire=1, next FETCH (behaves as nop; PC already advanced).
  - Otherwise next EXE.
- EXE (EOp/ALUSrc/ALUOp held per instruction):
  - addu ALUOp 000, subu 001, ori 010, lui 011, lw/sw 000 with ALUSrc=1.
  - beq: ALUOp 001, NPCOp=01, PCWr=zero, retire=1, next FETCH.
  - j: NPCOp=10, PCWr=1, retire=1, next FETCH.
  - jal: NPCOp=10, PCWr=1, next WB. The PC+4 needed for $31 is latched in the datapath before PCWr.
  - lw/sw: next MEM. All R-type and immediate ops: next WB.
- MEM:
  - dm_req=1. MemWr=1 for sw, held until dm_ready.
  - Stays in MEM while !dm_ready.
  - On dm_ready: sw gives retire=1, next FETCH; lw gives next WB.
- WB:
  - RegWr=1, retire=1, next FETCH.
  - addu/subu: RegDst=01, MemtoReg=00. ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01. jal: RegDst=10, MemtoReg=10.
- Enable exclusivity: RegWr, MemWr and IRWr are never high outside WB, MEM and FETCH respectively.
- retired_cnt: increments by 1 on each clock edge where retire=1. Wraps from all-ones to 0 with no flag.
- Unused select outputs are 0 in states where they don't matter.

Test Plan:
- Reset pulse mid-MEM of sw with dm_ready=0 -> state=0 immediately (async), MemWr=0, retired_cnt=0. After release, first edge with im_ready=1 gives IRWr=PCWr=1.
- ori $t0,$0,0xFFFF with im_ready=1, dm_ready=1 -> states 0,1,2,4. EOp=01 and ALUSrc=1 in EXE; RegWr=1, RegDst=00 in WB. 4 cycles, retired_cnt=1.
- lw with dm_ready low for 3 MEM cycles -> MEM held 4 cycles with dm_req=1, MemWr=0. Then WB with MemtoReg=01. Total 8 cycles.
- beq with zero=1, then zero=0 -> PCWr=1 / PCWr=0 in EXE, NPCOp=01, EOp=11. Each takes 3 cycles and pulses retire.
- jal -> EXE: PCWr=1, NPCOp=10. WB: RegDst=10, MemtoReg=10, RegWr=1.
- Illegal op 0x3F, then im_ready stuck low 5 cycles -> DECODE->FETCH with retire=1. FETCH holds with IRWr=0.
- Wrap: CNT_W=4, 16 retires -> retired_cnt returns to 0.
